// File: rtl/i2c_sensor_poller.sv
// -----------------------------------------------------------------------------
// i2c_sensor_poller
//
// Upstream sequencer for an I2C master. Once start_en is raised it writes one
// init register to the sensor, then repeatedly reads a bank of NUM_REGS 16-bit
// registers (REG_BASE, REG_BASE+2, ...). Successful reads are presented as
// indexed samples; failed transactions are counted in a saturating counter.
//
// Optional feature (macro POLLER_RETRY_EN):
//   defined   - a failed read (error or request timeout) is reissued once for
//               the same index; only the second failure counts and skips it.
//   undefined - every failure counts and the index is skipped.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   start_en      in   level; polling runs while high
//   i2c_en        out  transaction request to the master
//   i2c_rw        out  0 = write, 1 = read
//   i2c_addr      out  7-bit device address (always DEV_ADDR)
//   i2c_reg_addr  out  target register
//   i2c_data      out  write data (INIT_DATA during init, 0 otherwise)
//   i2c_burst     out  constant 0
//   i2c_busy      in   master busy
//   i2c_err       in   master error flag, valid when busy falls
//   i2c_data_o    in   master read data, valid when busy falls
//   ready         out  init write completed successfully
//   sample_valid  out  one-cycle sample strobe
//   sample_idx    out  register index of the sample
//   sample_data   out  sample value
//   err_count     out  saturating failed-transaction count
//   dbg_state     out  current FSM state encoding (observation only)
//
// Handshake: a request is raised by holding i2c_en=1 with rw/reg_addr/data
// stable; the master accepts it by raising i2c_busy, after which i2c_en drops
// on the next edge. The transaction completes on the busy falling edge
// (busy 1 in the previous cycle, 0 now), when i2c_err/i2c_data_o are taken.
// sample_valid is a single-cycle strobe with no back-pressure.
// -----------------------------------------------------------------------------
module i2c_sensor_poller #(
    parameter logic [6:0]  DEV_ADDR    = 7'h68,
    parameter logic [7:0]  INIT_REG    = 8'h6B,
    parameter logic [15:0] INIT_DATA   = 16'h0000,
    parameter logic [7:0]  REG_BASE    = 8'h3B,
    parameter int          NUM_REGS    = 3,
    parameter int          POLL_PERIOD = 100000,
    parameter int          REQ_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_en,
    output logic        i2c_en,
    output logic        i2c_rw,
    output logic [6:0]  i2c_addr,
    output logic [7:0]  i2c_reg_addr,
    output logic [15:0] i2c_data,
    output logic        i2c_burst,
    input  logic        i2c_busy,
    input  logic        i2c_err,
    input  logic [15:0] i2c_data_o,
    output logic        ready,
    output logic        sample_valid,
    output logic [1:0]  sample_idx,
    output logic [15:0] sample_data,
    output logic [7:0]  err_count,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT_REQ  = 3'd1,
        INIT_WAIT = 3'd2,
        PERIOD    = 3'd3,
        RD_REQ    = 3'd4,
        RD_WAIT   = 3'd5
    } state_t;

    localparam logic [31:0] PERIOD_LOAD  = 32'(POLL_PERIOD - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(REQ_TIMEOUT - 1);
    localparam logic [1:0]  LAST_IDX     = 2'(NUM_REGS - 1);

    state_t      state;
    logic [1:0]  idx;
    logic [31:0] cnt;      // request timeout count in REQ states, countdown in PERIOD
    logic        busy_q;
    logic        busy_fall;
`ifdef POLLER_RETRY_EN
    logic        retried;  // current idx has already been reissued once
`endif

    assign busy_fall = busy_q & ~i2c_busy;
    assign dbg_state = state;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= 2'd0;
            cnt          <= 32'd0;
            busy_q       <= 1'b0;
            i2c_en       <= 1'b0;
            i2c_rw       <= 1'b0;
            i2c_addr     <= DEV_ADDR;
            i2c_reg_addr <= 8'h00;
            i2c_data     <= 16'h0000;
            i2c_burst    <= 1'b0;
            ready        <= 1'b0;
            sample_valid <= 1'b0;
            sample_idx   <= 2'd0;
            sample_data  <= 16'h0000;
            err_count    <= 8'h00;
`ifdef POLLER_RETRY_EN
            retried      <= 1'b0;
`endif
        end else begin
            busy_q       <= i2c_busy;
            sample_valid <= 1'b0;
            i2c_addr     <= DEV_ADDR;
            i2c_burst    <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_en) begin
                        if (ready) begin
                            state <= PERIOD;
                            cnt   <= PERIOD_LOAD;
                        end else begin
                            state <= INIT_REQ;
                        end
                    end
                end

                // First cycle in a REQ state raises the request even if busy
                // is already high; busy is only honoured once i2c_en is up.
                INIT_REQ: begin
                    if (!i2c_en) begin
                        i2c_en       <= 1'b1;
                        i2c_rw       <= 1'b0;
                        i2c_reg_addr <= INIT_REG;
                        i2c_data     <= INIT_DATA;
                        cnt          <= 32'd0;
                    end else if (i2c_busy) begin
                        i2c_en <= 1'b0;
                        state  <= INIT_WAIT;
                    end else if (cnt == TIMEOUT_LAST) begin
                        i2c_en    <= 1'b0;
                        err_count <= sat_inc(err_count);
                        state     <= PERIOD;
                        cnt       <= PERIOD_LOAD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                INIT_WAIT: begin
                    if (busy_fall) begin
                        if (i2c_err) begin
                            err_count <= sat_inc(err_count);
                        end else begin
                            ready <= 1'b1;
                        end
                        state <= PERIOD;
                        cnt   <= PERIOD_LOAD;
                    end
                end

                PERIOD: begin
                    if (!start_en) begin
                        state <= IDLE;
                    end else if (cnt == 32'd0) begin
                        state <= ready ? RD_REQ : INIT_REQ;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end

                RD_REQ: begin
                    if (!i2c_en) begin
                        i2c_en       <= 1'b1;
                        i2c_rw       <= 1'b1;
                        i2c_reg_addr <= REG_BASE + {5'b0, idx, 1'b0};
                        i2c_data     <= 16'h0000;
                        cnt          <= 32'd0;
                    end else if (i2c_busy) begin
                        i2c_en <= 1'b0;
                        state  <= RD_WAIT;
                    end else if (cnt == TIMEOUT_LAST) begin
                        i2c_en <= 1'b0;
`ifdef POLLER_RETRY_EN
                        if (!retried) begin
                            // Stay in RD_REQ: the request is raised again next cycle.
                            retried <= 1'b1;
                        end else begin
                            retried   <= 1'b0;
                            err_count <= sat_inc(err_count);
                            idx       <= 2'd0;
                            state     <= PERIOD;
                            cnt       <= PERIOD_LOAD;
                        end
`else
                        err_count <= sat_inc(err_count);
                        idx       <= 2'd0;
                        state     <= PERIOD;
                        cnt       <= PERIOD_LOAD;
`endif
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                RD_WAIT: begin
                    if (busy_fall) begin
                        if (!i2c_err) begin
                            sample_valid <= 1'b1;
                            sample_idx   <= idx;
                            sample_data  <= i2c_data_o;
`ifdef POLLER_RETRY_EN
                            retried      <= 1'b0;
`endif
                            if (idx == LAST_IDX) begin
                                idx   <= 2'd0;
                                state <= PERIOD;
                                cnt   <= PERIOD_LOAD;
                            end else begin
                                idx   <= idx + 2'd1;
                                state <= RD_REQ;
                            end
`ifdef POLLER_RETRY_EN
                        end else if (!retried) begin
                            retried <= 1'b1;
                            state   <= RD_REQ;
`endif
                        end else begin
`ifdef POLLER_RETRY_EN
                            retried   <= 1'b0;
`endif
                            err_count <= sat_inc(err_count);
                            if (idx == LAST_IDX) begin
                                idx   <= 2'd0;
                                state <= PERIOD;
                                cnt   <= PERIOD_LOAD;
                            end else begin
                                idx   <= idx + 2'd1;
                                state <= RD_REQ;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/i2c_sensor_poller.md
# i2c_sensor_poller

Upstream sequencer for the I2C master: after enable, it writes one init register to a sensor, then periodically reads a bank of 16-bit registers through the master's `en`/`busy`/`err` handshake. Each read result is presented as an indexed sample to the navigation logic. It owns the master's request inputs; `sda`/`scl` stay inside the master.

## Interface
Parameters:
- `DEV_ADDR`, 7'h68: 7-bit sensor address driven on `i2c_addr`.
- `INIT_REG`, 8'h6B: register written once after start.
- `INIT_DATA`, 16'h0000: value written to `INIT_REG`.
- `REG_BASE`, 8'h3B: first read register; register k is at `REG_BASE + 2*k` (mod 256).
- `NUM_REGS`, 3: registers per poll round; range 1..4.
- `POLL_PERIOD`, 100000: cycles between the end of one round and the start of the next; minimum 2.
- `REQ_TIMEOUT`, 1000: cycles allowed for `i2c_busy` to rise after `i2c_en`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start_en` in 1: level; polling runs while high.
- `i2c_en` out 1: transaction request to the master.
- `i2c_rw` out 1: 0 = write, 1 = read.
- `i2c_addr` out 7: always `DEV_ADDR`.
- `i2c_reg_addr` out 8: target register.
- `i2c_data` out 16: write data; `INIT_DATA` in init, 0 otherwise.
- `i2c_burst` out 1: constant 0.
- `i2c_busy` in 1: master busy.
- `i2c_err` in 1: master NACK/error flag, valid when busy falls.
- `i2c_data_o` in 16: master read data, valid when busy falls.
- `ready` out 1: init write completed OK.
- `sample_valid` out 1: one-cycle pulse.
- `sample_idx` out 2: register index of the sample.
- `sample_data` out 16: read value.
- `err_count` out 8: saturating count of failed transactions.

## Operation
- States: IDLE, INIT_REQ, INIT_WAIT, PERIOD, RD_REQ, RD_WAIT.
- **IDLE:** exit to INIT_REQ when `start_en`=1 and `ready`=0. Exit to PERIOD when `start_en`=1 and `ready`=1.
- **REQ states:** drive `i2c_en`=1 with the `rw`/`reg_addr`/`data` fields held stable.
  - `i2c_busy` sampled high: go to the matching WAIT state with `i2c_en`=0.
  - Timeout counter reaches `REQ_TIMEOUT`: count as a failure (`err_count`+1) and go to PERIOD.
- **WAIT states:** a falling edge of `i2c_busy` (previous cycle 1, this cycle 0) marks completion; `i2c_err` and `i2c_data_o` are sampled in that cycle.
  - INIT OK: `ready`=1, go to PERIOD.
  - INIT error: `err_count`+1, go to PERIOD. Init is retried after the period because `ready`=0 routes back to INIT_REQ.
  - RD OK: register `sample_data`/`sample_idx` and pulse `sample_valid`.
  - RD error: `err_count`+1, no pulse.
  - After either RD outcome: if idx < `NUM_REGS`-1, idx+1 and go to RD_REQ; otherwise idx=0 and go to PERIOD.
- **PERIOD:** load the counter with `POLL_PERIOD`-1 on entry and count down. At 0, go to INIT_REQ if `ready`=0, else RD_REQ.
- **`start_en` low:** takes effect only from PERIOD or IDLE, going to IDLE. An in-flight REQ/WAIT completes first; `ready` is retained.
- **`err_count`:** saturates at 255. It is cleared only by `rst`.

## Timing
- Reset values: all outputs 0, except `i2c_addr`=`DEV_ADDR`. State is IDLE, idx=0. `rst` asserted mid-transaction drops `i2c_en` asynchronously; the master is not otherwise aborted.
- Outputs are registered. `i2c_en` rises 1 cycle after entering a REQ state and falls on the edge after `i2c_busy` is sampled high.
- `sample_valid` pulses on the clock edge after the busy falling edge is detected, for exactly 1 cycle. The next RD request (`i2c_en`=1) follows 1 cycle later.
- If `i2c_busy` is already high on entry to a REQ state, `i2c_en` is still asserted for 1 cycle. WAIT is then entered, and completion is the next falling edge.
- If `i2c_err` and a timeout coincide, only one failure is counted.

## Configuration
- Macro: `POLLER_RETRY_EN`.
- Defined: a failed read (err or timeout) is reissued once immediately for the same idx. Only a second failure increments `err_count` and skips the index.
- Undefined: no retry; each failure counts and skips the index.

## Test plan
- **Init write:** reset, `start_en`=1, master model acks with busy high for 20 cycles → `i2c_rw`=0, `i2c_reg_addr`=8'h6B, `i2c_data`=16'h0000; `ready`=1; `err_count`=0.
- **Read round:** `NUM_REGS`=3, `POLL_PERIOD`=10, model returns 16'h1234/16'h5678/16'h9ABC → three `sample_valid` pulses with idx 0/1/2 at reg 8'h3B/3D/3F and matching data; the next round starts 10 cycles after the last completion.
- **Read error:** `i2c_err`=1 on idx 1 → no pulse for idx 1; `err_count`=1; idx 2 is still read. With `POLLER_RETRY_EN` and a pass on retry → pulse for idx 1, `err_count`=0.
- **Timeout:** model never raises busy, `REQ_TIMEOUT`=50 → `i2c_en` is high for 50 cycles, then `err_count`+1 and state is PERIOD.
- **Stop and reset:** `start_en`=0 during RD_WAIT → the transaction completes, then IDLE with `i2c_en`=0. `rst` during RD_REQ → `i2c_en`=0 immediately and all outputs return to reset values.
- **Saturation:** 300 forced failures → `err_count`=255.
